// File: rtl/pe_feed_pkg.sv
// rtl/pe_feed_pkg.sv - state encoding and parameter defaults shared by the PE feed sequencer
package pe_feed_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOADW  = 3'd1,
    S_GAP    = 3'd2,
    S_STREAM = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  localparam int DEF_W   = 8;
  localparam int DEF_NW  = 150;
  localparam int DEF_NP  = 64;
  localparam int DEF_GAP = 25;
  localparam int DEF_AW  = 8;
  localparam int CW      = 16;

endpackage

// File: rtl/pe_feed_ram.sv
// rtl/pe_feed_ram.sv - one write port, one registered read port buffer for weights or pixels
module pe_feed_ram
  import pe_feed_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int DEPTH = DEF_NW,
  parameter int AW    = DEF_AW
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [2**AW];
  logic [W-1:0] rdata_q;
  logic         wr;

  assign wr = we_i && (int'(waddr_i) < DEPTH);

  // write-first: a read of the address being written returns the new data
  always_ff @(posedge clk) begin
    if (wr) mem_q[waddr_i] <= wdata_i;
    rdata_q <= (wr && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pe_feed_sequencer.sv
// rtl/pe_feed_sequencer.sv - loads NW weights, waits GAP cycles, then streams NP pixels into a PE
module pe_feed_sequencer
  import pe_feed_pkg::*;
#(
  parameter int W   = DEF_W,
  parameter int NW  = DEF_NW,
  parameter int NP  = DEF_NP,
  parameter int GAP = DEF_GAP,
  parameter int AW  = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          host_we,
  input  logic          host_sel,
  input  logic [AW-1:0] host_addr,
  input  logic [W-1:0]  host_data,
  input  logic          go,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          we,
  output logic [W-1:0]  weight_in,
  output logic          start,
  output logic [W-1:0]  indata
);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d, done_q, done_d, we_q, we_d, start_q, start_d;
  logic [W-1:0]  weight_q, weight_d, indata_q, indata_d;
  logic          wr_w, wr_p, last_w, last_g, last_p;
  logic [AW-1:0] w_raddr, p_raddr;
  logic [W-1:0]  w_rdata, p_rdata, w_first;

  assign wr_w   = host_we && (state_q == S_IDLE) && !host_sel;
  assign wr_p   = host_we && (state_q == S_IDLE) && host_sel;
  assign last_w = (cnt_q == CW'(NW - 1));
  assign last_g = (cnt_q == CW'(GAP - 1));
  assign last_p = (cnt_q == CW'(NP - 1));

  // word 0 was prefetched last cycle, so a same-cycle host write to it must bypass the RAM
  assign w_first = (wr_w && (host_addr == '0)) ? host_data : w_rdata;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (go) state_d = S_LOADW;
      S_LOADW:  if (abort) state_d = S_IDLE;
                else if (last_w) state_d = (GAP == 0) ? S_STREAM : S_GAP;
      S_GAP:    if (abort) state_d = S_IDLE;
                else if (last_g) state_d = S_STREAM;
      S_STREAM: if (abort) state_d = S_IDLE;
                else if (last_p) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    cnt_d = ((state_d != state_q) || (state_d == S_IDLE)) ? '0 : cnt_q + 1'b1;

    // read addresses run two words ahead of the output: RAM register plus output register
    w_raddr = '0;
    if (state_q == S_LOADW) w_raddr = AW'(cnt_q + CW'(2));
    else if (state_d == S_LOADW) w_raddr = AW'(1);
    p_raddr = '0;
    if (state_q == S_STREAM) p_raddr = AW'(cnt_q + CW'(2));
    else if (state_d == S_STREAM) p_raddr = AW'(1);

    we_d     = (state_d == S_LOADW);
    start_d  = (state_d == S_STREAM);
    busy_d   = we_d || start_d || (state_d == S_GAP);
    done_d   = (state_d == S_DONE);
    weight_d = '0;
    if (we_d) weight_d = (state_q == S_IDLE) ? w_first : w_rdata;
    indata_d = start_d ? p_rdata : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      start_q  <= 1'b0;
      weight_q <= '0;
      indata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      we_q     <= we_d;
      start_q  <= start_d;
      weight_q <= weight_d;
      indata_q <= indata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign we        = we_q;
  assign start     = start_q;
  assign weight_in = weight_q;
  assign indata    = indata_q;

  pe_feed_ram #(.W(W), .DEPTH(NW), .AW(AW)) u_wbuf (
    .clk(clk), .we_i(wr_w), .waddr_i(host_addr), .wdata_i(host_data),
    .raddr_i(w_raddr), .rdata_o(w_rdata)
  );

  pe_feed_ram #(.W(W), .DEPTH(NP), .AW(AW)) u_pbuf (
    .clk(clk), .we_i(wr_p), .waddr_i(host_addr), .wdata_i(host_data),
    .raddr_i(p_raddr), .rdata_o(p_rdata)
  );

endmodule

// File: tb/tb_pe_feed_sequencer.sv
// tb/tb_pe_feed_sequencer.sv - self-checking bench for pe_feed_sequencer with a cycle-offset model
module tb_pe_feed_sequencer;

  localparam int W   = 8;
  localparam int NW  = 150;
  localparam int NP  = 64;
  localparam int GAP = 25;
  localparam int AW  = 8;
  localparam int TOT = NW + GAP + NP;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          host_we = 1'b0, host_sel = 1'b0, go = 1'b0, abort = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [W-1:0]  host_data = '0;
  logic          busy, done, we, start;
  logic [W-1:0]  weight_in, indata;

  logic          s_we_h = 1'b0, s_sel = 1'b0, s_go = 1'b0, s_abort = 1'b0;
  logic [AW-1:0] s_addr = '0;
  logic [W-1:0]  s_data = '0;
  logic          s_busy, s_done, s_we, s_start;
  logic [W-1:0]  s_weight, s_indata;

  int mw [NW];
  int mp [NP];
  int m_c = -1;
  int errors = 0, checks = 0;
  int rel = -1, n_we = 0, n_start = 0, n_done = 0, done_rel = -1;
  int hist_w [256];
  int hist_in [256];

  pe_feed_sequencer #(.W(W), .NW(NW), .NP(NP), .GAP(GAP), .AW(AW)) dut (
    .clk(clk), .rst(rst), .host_we(host_we), .host_sel(host_sel), .host_addr(host_addr),
    .host_data(host_data), .go(go), .abort(abort), .busy(busy), .done(done), .we(we),
    .weight_in(weight_in), .start(start), .indata(indata)
  );

  pe_feed_sequencer #(.W(8), .NW(1), .NP(1), .GAP(0), .AW(8)) dut_s (
    .clk(clk), .rst(rst), .host_we(s_we_h), .host_sel(s_sel), .host_addr(s_addr),
    .host_data(s_data), .go(s_go), .abort(s_abort), .busy(s_busy), .done(s_done), .we(s_we),
    .weight_in(s_weight), .start(s_start), .indata(s_indata)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // m_c is the number of edges since the accepted go, -1 when idle
  task automatic compare();
    int ew, ei, eb, ed, ewe, est;
    ewe = (m_c >= 0 && m_c < NW) ? 1 : 0;
    est = (m_c >= NW + GAP && m_c < TOT) ? 1 : 0;
    eb  = (m_c >= 0 && m_c < TOT) ? 1 : 0;
    ed  = (m_c == TOT) ? 1 : 0;
    ew  = 0;
    ei  = 0;
    if (ewe == 1) ew = mw[m_c];
    if (est == 1) ei = mp[m_c - NW - GAP];
    check("we", int'(we), ewe);
    check("start", int'(start), est);
    check("busy", int'(busy), eb);
    check("done", int'(done), ed);
    check("weight_in", int'(weight_in), ew);
    check("indata", int'(indata), ei);
    check("we_start_exclusive", int'(we && start), 0);
  endtask

  task automatic tick();
    int a;
    @(posedge clk);
    a = int'(host_addr);
    if (rst) m_c = -1;
    else if (m_c < 0) begin
      if (host_we && !host_sel && a < NW) mw[a] = int'(host_data);
      if (host_we && host_sel && a < NP) mp[a] = int'(host_data);
      if (go) m_c = 0;
    end else if (m_c == TOT || abort) m_c = -1;
    else m_c++;
    #1;
    compare();
    if (rel >= 0 && rel < 256) begin
      hist_w[rel]  = int'(weight_in);
      hist_in[rel] = int'(indata);
      if (we) n_we++;
      if (start) n_start++;
      if (done) begin
        n_done++;
        done_rel = rel;
      end
      rel++;
    end
  endtask

  task automatic host_write(input bit sel, input int addr, input int data);
    host_we = 1'b1; host_sel = sel; host_addr = AW'(addr); host_data = W'(data);
    tick();
    host_we = 1'b0;
  endtask

  task automatic begin_run(input bit wr0);
    rel = 0; n_we = 0; n_start = 0; n_done = 0; done_rel = -1;
    if (wr0) begin
      host_we = 1'b1; host_sel = 1'b0; host_addr = '0; host_data = 8'h77;
    end
    go = 1'b1;
    tick();
    go = 1'b0; host_we = 1'b0;
  endtask

  task automatic run_seq(input bit wr0, input int go_at, input int wr_at, input int abort_at);
    begin_run(wr0);
    while (rel < TOT + 6) begin
      go    = (rel == go_at);
      abort = (rel == abort_at);
      if (rel == wr_at) begin
        host_we = 1'b1; host_sel = 1'b1; host_addr = '0; host_data = 8'h55;
      end
      tick();
      go = 1'b0; abort = 1'b0; host_we = 1'b0;
    end
    rel = -1;
  endtask

  initial begin
    repeat (3) tick();
    check("reset_busy", int'(busy), 0);
    check("reset_we", int'(we), 0);
    check("reset_weight_in", int'(weight_in), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < NW; i++) host_write(1'b0, i, (i % 10) + 1);
    for (int j = 0; j < NP; j++) host_write(1'b1, j, 10 + j);
    host_write(1'b0, 150, 8'hEE);
    host_write(1'b1, 64, 8'hEE);

    run_seq(1'b0, -1, -1, -1);
    check("run1_w0", hist_w[0], 1);
    check("run1_w9", hist_w[9], 10);
    check("run1_w10", hist_w[10], 1);
    check("run1_w149", hist_w[149], 10);
    check("run1_gap_w", hist_w[160], 0);
    check("run1_in_first", hist_in[175], 10);
    check("run1_in_last", hist_in[238], 73);
    check("run1_we_cycles", n_we, 150);
    check("run1_start_cycles", n_start, 64);
    check("run1_done_edge", done_rel, 239);
    check("run1_done_count", n_done, 1);

    run_seq(1'b0, 50, 200, -1);
    check("run2_we_cycles", n_we, 150);
    check("run2_done_edge", done_rel, 239);

    run_seq(1'b0, -1, -1, 160);
    check("abort_start_cycles", n_start, 0);
    check("abort_done_count", n_done, 0);
    check("abort_we_cycles", n_we, 150);

    run_seq(1'b0, -1, -1, -1);
    check("rerun_w0", hist_w[0], 1);
    check("rerun_pbuf0_kept", hist_in[175], 10);
    check("rerun_done_edge", done_rel, 239);

    begin_run(1'b0);
    while (rel < 206) tick();
    check("pre_reset_pixel30", hist_in[205], 40);
    #2 rst = 1'b1;
    #1;
    check("async_rst_start", int'(start), 0);
    check("async_rst_indata", int'(indata), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_done", int'(done), 0);
    m_c = -1;
    rel = -1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    run_seq(1'b0, -1, -1, -1);
    check("post_reset_in0", hist_in[175], 10);
    check("post_reset_in30", hist_in[205], 40);
    check("post_reset_done_edge", done_rel, 239);

    run_seq(1'b1, -1, -1, -1);
    check("go_with_write_w0", hist_w[0], 119);
    check("go_with_write_w1", hist_w[1], 2);
    check("go_with_write_done_edge", done_rel, 239);

    s_we_h = 1'b1; s_sel = 1'b0; s_addr = '0; s_data = 8'h3C;
    tick();
    s_sel = 1'b1; s_data = 8'hA5;
    tick();
    s_we_h = 1'b0; s_go = 1'b1;
    tick();
    s_go = 1'b0;
    check("small_e1_we", int'(s_we), 1);
    check("small_e1_weight", int'(s_weight), 60);
    check("small_e1_start", int'(s_start), 0);
    tick();
    check("small_e2_we", int'(s_we), 0);
    check("small_e2_start", int'(s_start), 1);
    check("small_e2_indata", int'(s_indata), 165);
    tick();
    check("small_e3_done", int'(s_done), 1);
    check("small_e3_busy", int'(s_busy), 0);
    check("small_e3_start", int'(s_start), 0);
    tick();
    check("small_e4_done", int'(s_done), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
